// File: rtl/bpm_capture_pkg.sv
// Shared types and sizing for the BPM capture BRAM writer.
// Optional build macro: BPM_CAPTURE_TSTAMP_EN (trigger timestamp header in word 0).
package bpm_capture_pkg;

  // Ceiling log2 for sizing counters from the BRAM depth.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res = res + 1;
    return res;
  endfunction

  localparam int unsigned C_PORT_DWIDTH  = 32;
  localparam int unsigned C_SAMPLE_WIDTH = C_PORT_DWIDTH / 2;
  localparam int unsigned C_PORT_AWIDTH  = 32;
  localparam int unsigned C_NUM_WE       = 4;
  localparam int unsigned C_MEMSIZE      = 32'h4000;
  localparam int unsigned C_BASEADDR     = 32'h0;
  localparam int unsigned C_WORDS        = C_MEMSIZE / 4;
  localparam int unsigned C_CNT_W        = clog2(C_WORDS) + 1;

`ifdef BPM_CAPTURE_TSTAMP_EN
  localparam int unsigned C_HDR_WORDS    = 1;
`else
  localparam int unsigned C_HDR_WORDS    = 0;
`endif
  localparam int unsigned C_LIMIT_MAX    = C_WORDS - C_HDR_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_FLUSH,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [C_PORT_AWIDTH-1:0] addr;
    logic [C_PORT_DWIDTH-1:0] data;
  } bram_wr_t;

endpackage

// File: rtl/bpm_capture_bram_writer_if.sv
// Control, sample-stream and BRAM port-B bundle of the capture writer.
interface bpm_capture_bram_writer_if;
  import bpm_capture_pkg::*;

  logic                      Arm;
  logic                      Trigger;
  logic                      Stop;
  logic                      Abort;
  logic [C_CNT_W-2:0]        Num_Words;
  logic                      Smp_Valid;
  logic [C_SAMPLE_WIDTH-1:0] Smp_Data;
  logic                      Smp_Ready;
  logic                      Busy;
  logic                      Done;
  logic [C_CNT_W-1:0]        Word_Count;
  logic                      BRAM_Rst_B;
  logic                      BRAM_Clk_B;
  logic                      BRAM_EN_B;
  logic [C_NUM_WE-1:0]       BRAM_WEN_B;
  logic [C_PORT_AWIDTH-1:0]  BRAM_Addr_B;
  logic [C_PORT_DWIDTH-1:0]  BRAM_Dout_B;
  logic [C_PORT_DWIDTH-1:0]  BRAM_Din_B;

  modport slave (
    input  Arm, Trigger, Stop, Abort, Num_Words, Smp_Valid, Smp_Data, BRAM_Din_B,
    output Smp_Ready, Busy, Done, Word_Count,
    output BRAM_Rst_B, BRAM_Clk_B, BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B
  );

  modport master (
    output Arm, Trigger, Stop, Abort, Num_Words, Smp_Valid, Smp_Data, BRAM_Din_B,
    input  Smp_Ready, Busy, Done, Word_Count,
    input  BRAM_Rst_B, BRAM_Clk_B, BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B
  );

endinterface

// File: rtl/bpm_sample_packer.sv
// Pairs consecutive accepted samples into one BRAM word; first sample lands in the MS half.
module bpm_sample_packer
  import bpm_capture_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      accept,
  input  logic [C_SAMPLE_WIDTH-1:0] smp_data,
  output logic                      pending,
  output logic [C_SAMPLE_WIDTH-1:0] half_data,
  output logic                      word_valid_c,
  output logic [C_PORT_DWIDTH-1:0]  word_c
);

  // Holds the first half of a pair until its partner arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      half_data <= '0;
    end else if (clear) begin
      pending   <= 1'b0;
    end else if (accept) begin
      if (pending) begin
        pending   <= 1'b0;
      end else begin
        pending   <= 1'b1;
        half_data <= smp_data;
      end
    end
  end

  assign word_valid_c = accept & pending;
  assign word_c       = {half_data, smp_data};

endmodule

// File: rtl/bpm_capture_bram_writer.sv
// Arm/trigger capture of the BPM sample stream into MicroBlaze BRAM via port B.
// Optional build macro: BPM_CAPTURE_TSTAMP_EN (cycle-count header in word 0).
module bpm_capture_bram_writer
  import bpm_capture_pkg::*;
(
  input  logic                       Clk,
  input  logic                       Rst_N,
  bpm_capture_bram_writer_if.slave   bus
);

  state_t                    state_q;
  state_t                    state_d;
  logic                      busy_q;
  logic                      ready_q;
  logic                      done_q;
  logic                      en_q;
  logic [C_NUM_WE-1:0]       wen_q;
  logic [C_CNT_W-1:0]        count_q;
  logic [C_CNT_W-1:0]        limit_q;
  bram_wr_t                  bram_q;

  logic                      accept_c;
  logic                      arm_ok_c;
  logic                      clear_c;
  logic                      limit_hit_c;
  logic                      wr_c;
  bram_wr_t                  wr_req_c;
  logic [C_CNT_W-1:0]        nw_limit_c;
  logic [C_CNT_W-1:0]        count_inc_c;
  logic [C_CNT_W-1:0]        wr_idx_c;

  logic                      pending;
  logic [C_SAMPLE_WIDTH-1:0] half_data;
  logic                      word_valid_c;
  logic [C_PORT_DWIDTH-1:0]  word_c;
  logic                      unused_din;

  assign accept_c    = bus.Smp_Valid & ready_q;
  assign arm_ok_c    = bus.Arm & ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // A half word never survives leaving CAPTURE; Stop flushes it through wr_req_c instead.
  assign clear_c     = bus.Abort | bus.Stop | (state_q != ST_CAPTURE);
  assign count_inc_c = count_q + C_CNT_W'(1);
  assign wr_idx_c    = count_q + C_CNT_W'(C_HDR_WORDS);
  assign limit_hit_c = word_valid_c && (count_inc_c == limit_q);

  bpm_sample_packer u_packer (
    .clk          (Clk),
    .rst_n        (Rst_N),
    .clear        (clear_c),
    .accept       (accept_c),
    .smp_data     (bus.Smp_Data),
    .pending      (pending),
    .half_data    (half_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // Requested length, saturated to what fits after any header word.
  always_comb begin
    nw_limit_c = C_CNT_W'(C_LIMIT_MAX);
    if ((bus.Num_Words != '0) && (C_CNT_W'(bus.Num_Words) <= C_CNT_W'(C_LIMIT_MAX)))
      nw_limit_c = C_CNT_W'(bus.Num_Words);
  end

  // Sample-word write request: full pair, or a zero-padded half word on Stop.
  always_comb begin
    wr_c          = 1'b0;
    wr_req_c.addr = C_PORT_AWIDTH'(C_BASEADDR) + (C_PORT_AWIDTH'(wr_idx_c) << 2);
    wr_req_c.data = word_c;
    if (word_valid_c) begin
      wr_c = 1'b1;
    end else if ((state_q == ST_CAPTURE) && bus.Stop) begin
      if (accept_c) begin
        wr_c          = 1'b1;
        wr_req_c.data = {bus.Smp_Data, {C_SAMPLE_WIDTH{1'b0}}};
      end else if (pending) begin
        wr_c          = 1'b1;
        wr_req_c.data = {half_data, {C_SAMPLE_WIDTH{1'b0}}};
      end
    end
  end

  // Next state; Abort overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.Arm) state_d = ST_ARMED;
      ST_ARMED:   if (bus.Trigger) state_d = ST_CAPTURE;
      ST_CAPTURE: if (bus.Stop || limit_hit_c) state_d = ST_FLUSH;
      ST_FLUSH:   state_d = ST_DONE;
      ST_DONE:    if (bus.Arm) state_d = ST_ARMED;
      default:    state_d = ST_IDLE;
    endcase
    if (bus.Abort) state_d = ST_IDLE;
  end

`ifdef BPM_CAPTURE_TSTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) ts_q <= '0;
    else        ts_q <= ts_q + 32'd1;
  end
`endif

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      wen_q   <= '0;
      count_q <= '0;
      limit_q <= '0;
      bram_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE) || (state_d == ST_FLUSH);
      ready_q <= (state_d == ST_CAPTURE);
      en_q    <= 1'b0;
      wen_q   <= '0;
      if (bus.Abort) begin
        done_q  <= 1'b0;
        count_q <= '0;
      end else begin
        if (arm_ok_c) begin
          done_q  <= 1'b0;
          count_q <= '0;
        end
        if (state_q == ST_FLUSH) done_q <= 1'b1;
        if ((state_q == ST_ARMED) && bus.Trigger) begin
          limit_q <= nw_limit_c;
`ifdef BPM_CAPTURE_TSTAMP_EN
          en_q        <= 1'b1;
          wen_q       <= '1;
          bram_q.addr <= C_PORT_AWIDTH'(C_BASEADDR);
          bram_q.data <= C_PORT_DWIDTH'(ts_q);
`endif
        end
        if (wr_c) begin
          en_q    <= 1'b1;
          wen_q   <= '1;
          bram_q  <= wr_req_c;
          count_q <= count_inc_c;
        end
      end
    end
  end

  assign unused_din       = ^bus.BRAM_Din_B;

  assign bus.Smp_Ready    = ready_q;
  assign bus.Busy         = busy_q;
  assign bus.Done         = done_q;
  assign bus.Word_Count   = count_q;
  assign bus.BRAM_Rst_B   = 1'b0;
  assign bus.BRAM_Clk_B   = Clk;
  assign bus.BRAM_EN_B    = en_q;
  assign bus.BRAM_WEN_B   = wen_q;
  assign bus.BRAM_Addr_B  = bram_q.addr;
  assign bus.BRAM_Dout_B  = bram_q.data;

endmodule

// File: tb/tb_bpm_capture_bram_writer.sv
// Self-checking bench for bpm_capture_bram_writer against a queue-based capture model.
module tb_bpm_capture_bram_writer;

`ifdef BPM_CAPTURE_TSTAMP_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int LMAX = 4096 - HDR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bpm_capture_bram_writer_if bus();

  bpm_capture_bram_writer dut (
    .Clk   (clk),
    .Rst_N (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  longint unsigned cyc;
  logic [63:0] wr_q[$];
  logic [63:0] exp_q[$];
  logic [15:0] smp[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Free-running cycle reference used for the timestamp header.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Write monitor: every enabled cycle is a BRAM write.
  always @(negedge clk) begin
    if (bus.BRAM_EN_B === 1'b1) begin
      wr_q.push_back({bus.BRAM_Addr_B, bus.BRAM_Dout_B});
      chk("wen_on", 64'(bus.BRAM_WEN_B), 64'hF);
    end else begin
      chk("wen_off", 64'(bus.BRAM_WEN_B), 64'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_capture(input string tag, input int nw, input int n, input int mode,
                             input bit toggle, input int base_val, input bit arm_mid);
    longint unsigned ts;
    int lim, nwords, exp_wc;
    bit exp_en;
    logic [15:0] hi, lo;
    smp.delete();
    for (int i = 0; i < n; i++)
      smp.push_back((base_val < 0) ? 16'($urandom) : 16'(base_val + i));
    wr_q.delete();
    bus.Num_Words = 12'(nw);
    bus.Arm = 1'b1;
    tick();
    bus.Arm = 1'b0;
    chk({tag, "_busy_armed"}, 64'(bus.Busy), 64'h1);
    chk({tag, "_done_clr"}, 64'(bus.Done), 64'h0);
    chk({tag, "_wc_clr"}, 64'(bus.Word_Count), 64'h0);
    bus.Trigger = 1'b1;
    ts = cyc;
    tick();
    bus.Trigger = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.Smp_Valid = 1'b1;
      bus.Smp_Data  = smp[i];
      if (mode == 2 && i == n - 1) bus.Stop = 1'b1;
      if (arm_mid && i == 2) bus.Arm = 1'b1;
      chk($sformatf("%s_ready%0d", tag, i), 64'(bus.Smp_Ready), 64'h1);
      tick();
      bus.Smp_Valid = 1'b0;
      bus.Stop = 1'b0;
      bus.Arm = 1'b0;
      exp_en = ((i % 2) == 1) || (mode == 2 && i == n - 1);
      exp_wc = (i + 1) / 2 + ((mode == 2 && i == n - 1 && (i % 2) == 0) ? 1 : 0);
      chk($sformatf("%s_en%0d", tag, i), 64'(bus.BRAM_EN_B), 64'(exp_en));
      chk($sformatf("%s_wc%0d", tag, i), 64'(bus.Word_Count), 64'(exp_wc));
      if (toggle) tick();
    end
    if (mode == 1) begin
      bus.Stop = 1'b1;
      tick();
      bus.Stop = 1'b0;
      chk({tag, "_flush_en"}, 64'(bus.BRAM_EN_B), 64'((n % 2) == 1));
    end
    for (int k = 0; k < 50 && bus.Done !== 1'b1; k++) tick();
    tick();
    chk({tag, "_done"}, 64'(bus.Done), 64'h1);
    chk({tag, "_busy_end"}, 64'(bus.Busy), 64'h0);
    chk({tag, "_ready_end"}, 64'(bus.Smp_Ready), 64'h0);

    // Reference: words from consecutive sample pairs, bounded by the limit.
    lim = (nw == 0 || nw > LMAX) ? LMAX : nw;
    nwords = (mode != 0) ? (n + 1) / 2 : n / 2;
    if (nwords > lim) nwords = lim;
    exp_q.delete();
    if (HDR == 1) exp_q.push_back({32'h0, 32'(ts)});
    for (int w = 0; w < nwords; w++) begin
      hi = smp[2 * w];
      lo = (2 * w + 1 < n) ? smp[2 * w + 1] : 16'h0;
      exp_q.push_back({32'(4 * (HDR + w)), hi, lo});
    end
    chk({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), wr_q[i], exp_q[i]);
    chk({tag, "_word_count"}, 64'(bus.Word_Count), 64'(nwords));
    if (exp_q.size() > 0) begin
      hi = 16'h0;
      chk({tag, "_addr_hold"}, 64'(bus.BRAM_Addr_B), 64'(exp_q[exp_q.size() - 1][63:32]));
    end
  endtask

  initial begin
    bus.Arm = 1'b0;
    bus.Trigger = 1'b0;
    bus.Stop = 1'b0;
    bus.Abort = 1'b0;
    bus.Num_Words = '0;
    bus.Smp_Valid = 1'b0;
    bus.Smp_Data = '0;
    bus.BRAM_Din_B = '0;

    // Reset state
    #2;
    chk("rst_en", 64'(bus.BRAM_EN_B), 64'h0);
    chk("rst_addr", 64'(bus.BRAM_Addr_B), 64'h0);
    chk("rst_dout", 64'(bus.BRAM_Dout_B), 64'h0);
    chk("rst_busy", 64'(bus.Busy), 64'h0);
    chk("rst_done", 64'(bus.Done), 64'h0);
    chk("rst_wc", 64'(bus.Word_Count), 64'h0);
    chk("rst_ready", 64'(bus.Smp_Ready), 64'h0);
    chk("rst_bram_rst", 64'(bus.BRAM_Rst_B), 64'h0);
    chk("bram_clk", 64'(bus.BRAM_Clk_B), 64'(clk));
    #20;
    rst_n = 1'b1;
    tick();

    // Trigger before Arm is ignored
    bus.Trigger = 1'b1;
    tick();
    bus.Trigger = 1'b0;
    tick();
    chk("early_trig_busy", 64'(bus.Busy), 64'h0);
    chk("early_trig_ready", 64'(bus.Smp_Ready), 64'h0);

    // Basic 4-word capture, consecutive samples
    run_capture("t1", 4, 8, 0, 1'b0, 1, 1'b0);
    // Same words with Valid toggling
    run_capture("t2", 4, 8, 0, 1'b1, 1, 1'b0);
    // Stop after an odd sample count
    run_capture("t3", 4, 5, 1, 1'b0, 1, 1'b0);
    // Stop in the same cycle as a completing pair, and with a lone sample
    run_capture("t3b", 0, 6, 2, 1'b0, -1, 1'b0);
    run_capture("t3c", 0, 3, 2, 1'b0, -1, 1'b0);
    run_capture("t3d", 9, 4, 1, 1'b1, -1, 1'b0);
    // Arm during capture is ignored
    run_capture("t6", 5, 10, 0, 1'b0, -1, 1'b1);
    // Trigger in DONE is ignored; Arm from DONE starts a fresh capture
    bus.Trigger = 1'b1;
    tick();
    bus.Trigger = 1'b0;
    tick();
    chk("done_trig_busy", 64'(bus.Busy), 64'h0);
    chk("done_trig_done", 64'(bus.Done), 64'h1);
    for (int r = 0; r < 3; r++) begin
      int nwr;
      nwr = int'($urandom_range(1, 12));
      run_capture($sformatf("rnd%0d", r), nwr, 2 * nwr, 0, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    // Abort mid-capture
    wr_q.delete();
    bus.Num_Words = 12'd8;
    bus.Arm = 1'b1;
    tick();
    bus.Arm = 1'b0;
    bus.Trigger = 1'b1;
    tick();
    bus.Trigger = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.Smp_Valid = 1'b1;
      bus.Smp_Data = 16'(16'hA0 + i);
      tick();
    end
    bus.Smp_Valid = 1'b0;
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    chk("abort_busy", 64'(bus.Busy), 64'h0);
    chk("abort_done", 64'(bus.Done), 64'h0);
    chk("abort_wc", 64'(bus.Word_Count), 64'h0);
    chk("abort_ready", 64'(bus.Smp_Ready), 64'h0);
    tick();
    tick();
    chk("abort_nwrites", 64'(wr_q.size()), 64'h1);
    if (wr_q.size() > 0) chk("abort_word0", wr_q[0], {32'(4 * HDR), 32'h00A000A1});

    // Reset asserted during a write
    wr_q.delete();
    bus.Arm = 1'b1;
    tick();
    bus.Arm = 1'b0;
    bus.Trigger = 1'b1;
    tick();
    bus.Trigger = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.Smp_Valid = 1'b1;
      bus.Smp_Data = 16'(16'h55 + i);
      tick();
    end
    chk("pre_reset_en", 64'(bus.BRAM_EN_B), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("reset_en", 64'(bus.BRAM_EN_B), 64'h0);
    chk("reset_wen", 64'(bus.BRAM_WEN_B), 64'h0);
    chk("reset_wc", 64'(bus.Word_Count), 64'h0);
    chk("reset_busy", 64'(bus.Busy), 64'h0);
    tick();
    tick();
    bus.Smp_Valid = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("reset_nwrites", 64'(wr_q.size()), 64'h0);
    chk("post_reset_busy", 64'(bus.Busy), 64'h0);
    chk("post_reset_done", 64'(bus.Done), 64'h0);

    // Full-memory capture (Num_Words = 0)
    run_capture("t5", 0, 2 * LMAX, 0, 1'b0, -1, 1'b0);
    chk("t5_last_addr", 64'(bus.BRAM_Addr_B), 64'h3FFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
